// File: rtl/pong_color_pipe.sv
// pong_color_pipe: priority-mapped RGB for NUM_OBJ rectangles, run-time palette, per-object hit flash; 2-cycle latency.
// No backpressure: accepts one pixel per cycle, never stalls.
module pong_color_pipe #(
  parameter int NUM_OBJ      = 4,
  parameter int COORD_W      = 10,
  parameter int COLOR_W      = 8,
  parameter int FLASH_FRAMES = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [COORD_W-1:0]           DrawX,
  input  logic [COORD_W-1:0]           DrawY,
  input  logic                         Pix_valid,
  input  logic                         Frame_start,
  input  logic [NUM_OBJ*COORD_W-1:0]   Obj_X,
  input  logic [NUM_OBJ*COORD_W-1:0]   Obj_Y,
  input  logic [NUM_OBJ*COORD_W-1:0]   Obj_HalfW,
  input  logic [NUM_OBJ*COORD_W-1:0]   Obj_HalfH,
  input  logic [NUM_OBJ-1:0]           Obj_en,
  input  logic [NUM_OBJ-1:0]           Hit,
  input  logic                         Pal_we,
  input  logic [$clog2(NUM_OBJ+1)-1:0] Pal_addr,
  input  logic [3*COLOR_W-1:0]         Pal_data,
  output logic [COLOR_W-1:0]           Red,
  output logic [COLOR_W-1:0]           Green,
  output logic [COLOR_W-1:0]           Blue,
  output logic                         Out_valid
);

  localparam int CW = COORD_W + 1;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // 8-bit reference colours are aligned to the channel MSB.
  function automatic logic [COLOR_W-1:0] scale8(input logic [7:0] v);
    logic [COLOR_W-1:0] r;
    int src;
    r = '0;
    for (int b = 0; b < COLOR_W; b++) begin
      src = b - (COLOR_W - 8);
      if (src >= 0 && src < 8) r[b] = v[src[2:0]];
    end
    return r;
  endfunction

  function automatic rgb_t pal_default(input int idx);
    rgb_t c;
    if (idx == 0)      c = '{r: scale8(8'h00), g: scale8(8'h00), b: scale8(8'h7F)};
    else if (idx == 1) c = '{r: scale8(8'hFF), g: scale8(8'h00), b: scale8(8'h00)};
    else               c = '{r: scale8(8'hFF), g: scale8(8'hFF), b: scale8(8'hFF)};
    return c;
  endfunction

  // Extra bit keeps c+h from truncating; the low bound clamps at zero.
  function automatic logic in_span(input logic [COORD_W-1:0] c,
                                   input logic [COORD_W-1:0] h,
                                   input logic [COORD_W-1:0] p);
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;
    lo = (c < h) ? '0 : (CW'(c) - CW'(h));
    hi = CW'(c) + CW'(h);
    return (CW'(p) >= lo) && (CW'(p) <= hi);
  endfunction

  rgb_t               pal [NUM_OBJ+1];
  logic [7:0]         flash_cnt [NUM_OBJ];
  logic [NUM_OBJ-1:0] hit_d;
  logic [NUM_OBJ-1:0] flash_d;
  logic [NUM_OBJ-1:0] hit_q;
  logic [NUM_OBJ-1:0] flash_q;
  logic               v1;
  rgb_t               col;

  always_comb begin
    hit_d   = '0;
    flash_d = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      hit_d[i] = Obj_en[i]
              && in_span(Obj_X[i*COORD_W +: COORD_W], Obj_HalfW[i*COORD_W +: COORD_W], DrawX)
              && in_span(Obj_Y[i*COORD_W +: COORD_W], Obj_HalfH[i*COORD_W +: COORD_W], DrawY);
      flash_d[i] = (flash_cnt[i] != 8'd0);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_OBJ; i++) flash_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (Hit[i])
          flash_cnt[i] <= 8'(FLASH_FRAMES);
        else if (Frame_start && flash_cnt[i] != 8'd0)
          flash_cnt[i] <= flash_cnt[i] - 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int j = 0; j <= NUM_OBJ; j++) pal[j] <= pal_default(j);
    end else if (Pal_we && (int'(Pal_addr) <= NUM_OBJ)) begin
      pal[Pal_addr] <= rgb_t'(Pal_data);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v1      <= 1'b0;
      hit_q   <= '0;
      flash_q <= '0;
    end else begin
      v1      <= Pix_valid;
      hit_q   <= hit_d;
      flash_q <= flash_d;
    end
  end

  // Lowest index wins; only an object colour can be inverted.
  always_comb begin
    logic found;
    logic inv;
    found = 1'b0;
    inv   = 1'b0;
    col   = pal[0];
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!found && hit_q[i]) begin
        found = 1'b1;
        col   = pal[i+1];
        inv   = flash_q[i];
      end
    end
    if (inv) col = ~col;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      Out_valid <= 1'b0;
    end else begin
      Red       <= v1 ? col.r : '0;
      Green     <= v1 ? col.g : '0;
      Blue      <= v1 ? col.b : '0;
      Out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_pong_color_pipe.sv
// Directed bench for pong_color_pipe: vector tables plus hand sequences for palette timing, flash and reset.
module tb_pong_color_pipe;

  localparam logic [23:0] BG    = 24'h00007F;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] CYAN  = 24'h00FFFF;

  logic        Clk;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        Pix_valid, Frame_start;
  logic [39:0] Obj_X, Obj_Y, Obj_HalfW, Obj_HalfH;
  logic [3:0]  Obj_en, Hit;
  logic        Pal_we;
  logic [2:0]  Pal_addr;
  logic [23:0] Pal_data;
  logic [7:0]  Red, Green, Blue;
  logic        Out_valid;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        v;
    logic [23:0] rgb;
    logic        ov;
  } vec_t;

  vec_t tbl [32];
  int   ntbl;

  pong_color_pipe dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .Pix_valid(Pix_valid), .Frame_start(Frame_start),
    .Obj_X(Obj_X), .Obj_Y(Obj_Y), .Obj_HalfW(Obj_HalfW), .Obj_HalfH(Obj_HalfH),
    .Obj_en(Obj_en), .Hit(Hit), .Pal_we(Pal_we), .Pal_addr(Pal_addr), .Pal_data(Pal_data),
    .Red(Red), .Green(Green), .Blue(Blue), .Out_valid(Out_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [23:0] exp_rgb, input logic exp_v);
    total++;
    if ({Red, Green, Blue} === exp_rgb && Out_valid === exp_v) passed++;
    else $display("FAIL %s: got rgb=%06h valid=%0b, expected rgb=%06h valid=%0b",
                  name, {Red, Green, Blue}, Out_valid, exp_rgb, exp_v);
  endtask

  task automatic set_obj(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] hw, input logic [9:0] hh);
    Obj_X[i*10 +: 10]     = x;
    Obj_Y[i*10 +: 10]     = y;
    Obj_HalfW[i*10 +: 10] = hw;
    Obj_HalfH[i*10 +: 10] = hh;
  endtask

  task automatic add(input logic [9:0] x, input logic [9:0] y, input logic v,
                     input logic [23:0] rgb, input logic ov);
    tbl[ntbl] = '{x, y, v, rgb, ov};
    ntbl++;
  endtask

  // Entry j is driven at negedge j and checked at negedge j+2.
  task automatic stream(input string tag);
    for (int i = 0; i < ntbl + 2; i++) begin
      @(negedge Clk);
      if (i >= 2) chk($sformatf("%s[%0d]", tag, i - 2), tbl[i-2].rgb, tbl[i-2].ov);
      if (i < ntbl) begin
        DrawX = tbl[i].x; DrawY = tbl[i].y; Pix_valid = tbl[i].v;
      end else begin
        Pix_valid = 1'b0;
      end
    end
    ntbl = 0;
  endtask

  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp_rgb,
                    input string name);
    @(negedge Clk);
    DrawX = x; DrawY = y; Pix_valid = 1'b1;
    @(negedge Clk);
    Pix_valid = 1'b0;
    @(negedge Clk);
    chk(name, exp_rgb, 1'b1);
  endtask

  task automatic pulse(input logic h0, input logic h1, input logic fs);
    @(negedge Clk);
    Hit = {2'b00, h1, h0}; Frame_start = fs;
    @(negedge Clk);
    Hit = '0; Frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; DrawX = '0; DrawY = '0; Pix_valid = 1'b0; Frame_start = 1'b0;
    Obj_X = '0; Obj_Y = '0; Obj_HalfW = '0; Obj_HalfH = '0; Obj_en = '0; Hit = '0;
    Pal_we = 1'b0; Pal_addr = '0; Pal_data = '0; ntbl = 0;
    #1 chk("reset_state", 24'h0, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    // Sweep across obj0, vertical edges, then alternating bubbles.
    set_obj(0, 10'd320, 10'd240, 10'd4, 10'd4);
    Obj_en = 4'b0001;
    for (int x = 314; x <= 326; x++)
      add(10'(x), 10'd240, 1'b1, (x >= 316 && x <= 324) ? RED : BG, 1'b1);
    add(10'd320, 10'd236, 1'b1, RED, 1'b1);
    add(10'd320, 10'd235, 1'b1, BG,  1'b1);
    add(10'd320, 10'd244, 1'b1, RED, 1'b1);
    add(10'd320, 10'd245, 1'b1, BG,  1'b1);
    add(10'd320, 10'd240, 1'b0, 24'h0, 1'b0);
    add(10'd320, 10'd240, 1'b1, RED, 1'b1);
    add(10'd0,   10'd0,   1'b0, 24'h0, 1'b0);
    add(10'd0,   10'd0,   1'b1, BG,  1'b1);
    add(10'd324, 10'd240, 1'b0, 24'h0, 1'b0);
    add(10'd324, 10'd240, 1'b1, RED, 1'b1);
    stream("sweep");

    // Low-side clamp on obj1.
    Obj_en = 4'b0010;
    set_obj(1, 10'd2, 10'd100, 10'd5, 10'd5);
    add(10'd0, 10'd100, 1'b1, WHITE, 1'b1);
    add(10'd7, 10'd100, 1'b1, WHITE, 1'b1);
    add(10'd8, 10'd100, 1'b1, BG,    1'b1);
    add(10'd0, 10'd105, 1'b1, WHITE, 1'b1);
    add(10'd0, 10'd106, 1'b1, BG,    1'b1);
    stream("clamp");

    // High side must not wrap past the coordinate range.
    set_obj(1, 10'd1020, 10'd100, 10'd10, 10'd5);
    add(10'd5,    10'd100, 1'b1, BG,    1'b1);
    add(10'd1010, 10'd100, 1'b1, WHITE, 1'b1);
    add(10'd1009, 10'd100, 1'b1, BG,    1'b1);
    add(10'd1023, 10'd100, 1'b1, WHITE, 1'b1);
    stream("wrap");

    // Overlap priority and palette write timing.
    do_reset();
    set_obj(0, 10'd100, 10'd100, 10'd4, 10'd4);
    set_obj(1, 10'd100, 10'd100, 10'd4, 10'd4);
    Obj_en = 4'b0011;
    @(negedge Clk);
    DrawX = 10'd100; DrawY = 10'd100; Pix_valid = 1'b1;
    @(negedge Clk);
    Pal_we = 1'b1; Pal_addr = 3'd1; Pal_data = GREEN;
    @(negedge Clk);
    Pal_we = 1'b0; Pix_valid = 1'b0;
    chk("pal_same_edge_old", RED, 1'b1);
    @(negedge Clk);
    chk("pal_next_new", GREEN, 1'b1);
    @(negedge Clk);
    Pal_we = 1'b1; Pal_addr = 3'd7; Pal_data = 24'h123456;
    @(negedge Clk);
    Pal_we = 1'b0;
    px(10'd0, 10'd0, BG, "pal_addr_ignored");
    pulse(1'b0, 1'b1, 1'b0);
    px(10'd100, 10'd100, GREEN, "prio_over_flash");

    // Disable takes effect for the pixel presented in that cycle.
    @(negedge Clk);
    DrawX = 10'd100; DrawY = 10'd100; Pix_valid = 1'b1;
    @(negedge Clk);
    Obj_en = 4'b0000;
    @(negedge Clk);
    Pix_valid = 1'b0;
    chk("disable_inflight", GREEN, 1'b1);
    @(negedge Clk);
    chk("disable_next", BG, 1'b1);

    // Flash timing in frames.
    do_reset();
    set_obj(0, 10'd320, 10'd240, 10'd4, 10'd4);
    Obj_en = 4'b0001;
    px(10'd320, 10'd240, RED, "flash_idle");
    pulse(1'b1, 1'b0, 1'b0);
    px(10'd320, 10'd240, CYAN, "flash_hit");
    px(10'd0, 10'd0, BG, "flash_bg_no_invert");
    repeat (15) pulse(1'b0, 1'b0, 1'b1);
    px(10'd320, 10'd240, CYAN, "flash_after_15");
    pulse(1'b0, 1'b0, 1'b1);
    px(10'd320, 10'd240, RED, "flash_after_16");
    pulse(1'b0, 1'b0, 1'b1);
    px(10'd320, 10'd240, RED, "flash_saturate");
    pulse(1'b1, 1'b0, 1'b0);
    repeat (5) pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b1);
    repeat (15) pulse(1'b0, 1'b0, 1'b1);
    px(10'd320, 10'd240, CYAN, "flash_coinc_15");
    pulse(1'b0, 1'b0, 1'b1);
    px(10'd320, 10'd240, RED, "flash_coinc_16");

    // Async reset mid-stream, then palette defaults restored.
    @(negedge Clk);
    Pal_we = 1'b1; Pal_addr = 3'd1; Pal_data = GREEN;
    @(negedge Clk);
    Pal_we = 1'b0;
    DrawX = 10'd320; DrawY = 10'd240; Pix_valid = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("pre_reset_pixel", GREEN, 1'b1);
    #2;
    Reset = 1'b0; Pix_valid = 1'b0;
    #1 chk("async_reset_now", 24'h0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("reset_discard_1", 24'h0, 1'b0);
    @(negedge Clk);
    chk("reset_discard_2", 24'h0, 1'b0);
    px(10'd320, 10'd240, RED, "pal_restored");
    px(10'd0, 10'd0, BG, "bg_restored");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
